// File: rtl/taxi_eth_mac_tx_arb_pkg.sv
// Shared constants and helpers for the MAC TX frame arbiter and completion demux.
package taxi_eth_mac_tx_arb_pkg;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned MAX_CL    = 4;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  typedef struct packed {
    logic              found;
    logic [MAX_CL-1:0] index;
  } rr_sel_t;

  // Port-index width; a single bit is kept even for degenerate port counts
  function automatic int unsigned cl_width(input int unsigned ports);
    return (ports > 1) ? int'($clog2(ports)) : 1;
  endfunction

  // First set request at or above ptr, wrapping at ports-1 back to 0
  function automatic rr_sel_t rr_select(input logic [MAX_PORTS-1:0] req,
                                        input logic [MAX_CL-1:0]    ptr,
                                        input int unsigned          ports);
    rr_sel_t     sel;
    int unsigned cand;
    sel = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= ports) cand = cand - ports;
      if (i < ports && !sel.found && req[cand[MAX_CL-1:0]]) begin
        sel.found = 1'b1;
        sel.index = cand[MAX_CL-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/taxi_eth_mac_tx_cpl_demux.sv
// Stateless router of MAC TX completions back to the queue named by the tid prefix.
module taxi_eth_mac_tx_cpl_demux
  import taxi_eth_mac_tx_arb_pkg::*;
#(
  parameter  int unsigned PORTS    = 4,
  parameter  int unsigned S_ID_W   = 8,
  parameter  int unsigned CPL_W    = 96,
  localparam int unsigned CL_PORTS = cl_width(PORTS),
  localparam int unsigned M_ID_W   = CL_PORTS + S_ID_W
) (
  input  logic [CPL_W-1:0]        s_cpl_tdata,
  input  logic [M_ID_W-1:0]       s_cpl_tid,
  input  logic                    s_cpl_tvalid,
  output logic                    s_cpl_tready,
  output logic [CPL_W-1:0]        m_cpl_tdata,
  output logic [PORTS*S_ID_W-1:0] m_cpl_tid,
  output logic [PORTS-1:0]        m_cpl_tvalid,
  input  logic [PORTS-1:0]        m_cpl_tready
);

  logic [CL_PORTS-1:0] cpl_port;

  assign cpl_port    = s_cpl_tid[M_ID_W-1:S_ID_W];
  assign m_cpl_tdata = s_cpl_tdata;
  assign m_cpl_tid   = {PORTS{s_cpl_tid[S_ID_W-1:0]}};

  // Steer valid to the addressed port; unknown ports are silently drained
  always_comb begin
    m_cpl_tvalid = '0;
    s_cpl_tready = 1'b1;
    if (32'(cpl_port) < PORTS) begin
      m_cpl_tvalid[cpl_port] = s_cpl_tvalid;
      s_cpl_tready           = m_cpl_tready[cpl_port];
    end
  end

endmodule

// File: rtl/taxi_eth_mac_tx_arb.sv
// Frame-granular round-robin arbiter sharing one MAC TX stream between PORTS queues.
module taxi_eth_mac_tx_arb
  import taxi_eth_mac_tx_arb_pkg::*;
#(
  parameter  int unsigned PORTS    = 4,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned USER_W   = 1,
  parameter  int unsigned S_ID_W   = 8,
  parameter  int unsigned CPL_W    = 96,
  localparam int unsigned CL_PORTS = cl_width(PORTS),
  localparam int unsigned M_ID_W   = CL_PORTS + S_ID_W
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  input  logic [PORTS*DATA_W-1:0] s_tdata,
  input  logic [PORTS-1:0]        s_tvalid,
  output logic [PORTS-1:0]        s_tready,
  input  logic [PORTS-1:0]        s_tlast,
  input  logic [PORTS*USER_W-1:0] s_tuser,
  input  logic [PORTS*S_ID_W-1:0] s_tid,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [USER_W-1:0]       m_tuser,
  output logic [M_ID_W-1:0]       m_tid,
  input  logic [CPL_W-1:0]        s_cpl_tdata,
  input  logic [M_ID_W-1:0]       s_cpl_tid,
  input  logic                    s_cpl_tvalid,
  output logic                    s_cpl_tready,
  output logic [CPL_W-1:0]        m_cpl_tdata,
  output logic [PORTS*S_ID_W-1:0] m_cpl_tid,
  output logic [PORTS-1:0]        m_cpl_tvalid,
  input  logic [PORTS-1:0]        m_cpl_tready,
  input  logic [PORTS-1:0]        cfg_port_en,
  output logic                    stat_grant_valid,
  output logic [CL_PORTS-1:0]     stat_grant_port,
  output logic [PORTS-1:0]        stat_frame_done
);

  logic [0:0]          state, state_d;
  logic [CL_PORTS-1:0] grant, grant_d;
  logic [CL_PORTS-1:0] rr_ptr, rr_ptr_d;
  logic [PORTS-1:0]    frame_done_d;
  logic [PORTS-1:0]    req;
  rr_sel_t             sel;

  logic [DATA_W-1:0] s_tdata_a [PORTS];
  logic [USER_W-1:0] s_tuser_a [PORTS];
  logic [S_ID_W-1:0] s_tid_a   [PORTS];

  // Split the flat per-port buses into indexable arrays
  for (genvar i = 0; i < int'(PORTS); i++) begin : g_unpack
    assign s_tdata_a[i] = s_tdata[i*DATA_W +: DATA_W];
    assign s_tuser_a[i] = s_tuser[i*USER_W +: USER_W];
    assign s_tid_a[i]   = s_tid[i*S_ID_W +: S_ID_W];
  end

  // Pass the granted port straight through while a frame is in progress
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    m_tid    = '0;
    if (state == ST_XFER) begin
      m_tvalid        = s_tvalid[grant];
      s_tready[grant] = m_tready;
      m_tdata         = s_tdata_a[grant];
      m_tlast         = s_tlast[grant];
      m_tuser         = s_tuser_a[grant];
      m_tid           = {grant, s_tid_a[grant]};
    end
  end

  // Next-state: arbitrate in IDLE, release the grant on the tlast handshake
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    rr_ptr_d     = rr_ptr;
    frame_done_d = '0;
    req          = s_tvalid & cfg_port_en;
    sel          = rr_select(MAX_PORTS'(req), MAX_CL'(rr_ptr), PORTS);
    case (state)
      ST_IDLE: begin
        if (sel.found) begin
          grant_d = CL_PORTS'(sel.index);
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (m_tvalid && m_tready && m_tlast) begin
          frame_done_d[grant] = 1'b1;
          rr_ptr_d = (grant == CL_PORTS'(PORTS - 1)) ? '0 : grant + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Grant, round-robin pointer and frame-done pulse registers
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      grant           <= '0;
      rr_ptr          <= '0;
      stat_frame_done <= '0;
    end else begin
      grant           <= grant_d;
      rr_ptr          <= rr_ptr_d;
      stat_frame_done <= frame_done_d;
    end
  end

  assign stat_grant_valid = (state == ST_XFER);
  assign stat_grant_port  = grant;

  taxi_eth_mac_tx_cpl_demux #(
    .PORTS  (PORTS),
    .S_ID_W (S_ID_W),
    .CPL_W  (CPL_W)
  ) u_cpl_demux (
    .s_cpl_tdata  (s_cpl_tdata),
    .s_cpl_tid    (s_cpl_tid),
    .s_cpl_tvalid (s_cpl_tvalid),
    .s_cpl_tready (s_cpl_tready),
    .m_cpl_tdata  (m_cpl_tdata),
    .m_cpl_tid    (m_cpl_tid),
    .m_cpl_tvalid (m_cpl_tvalid),
    .m_cpl_tready (m_cpl_tready)
  );

endmodule

// File: tb/tb_taxi_eth_mac_tx_arb.sv
// Scoreboard bench for the MAC TX arbiter (PORTS=4) plus a PORTS=3 completion-drop instance.
`timescale 1ns/1ps
module tb_taxi_eth_mac_tx_arb;

  localparam int unsigned PORTS = 4;
  localparam int unsigned CW    = 96;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic [9:0] tid;
  } beat_t;

  typedef struct {
    int port;
    int cyc;
  } done_t;

  typedef struct {
    int          port;
    logic [7:0]  tag;
    logic [95:0] data;
  } cpl_t;

  logic tx_clk = 1'b0;
  logic tx_rst = 1'b1;
  always #5 tx_clk = ~tx_clk;

  logic [PORTS*8-1:0] s_tdata;
  logic [PORTS-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
  logic [PORTS*8-1:0] s_tid;
  logic [7:0]         m_tdata;
  logic               m_tvalid, m_tlast;
  logic               m_tready = 1'b1;
  logic [0:0]         m_tuser;
  logic [9:0]         m_tid;
  logic [CW-1:0]      s_cpl_tdata;
  logic [9:0]         s_cpl_tid;
  logic               s_cpl_tvalid, s_cpl_tready;
  logic [CW-1:0]      m_cpl_tdata;
  logic [PORTS*8-1:0] m_cpl_tid;
  logic [PORTS-1:0]   m_cpl_tvalid, m_cpl_tready;
  logic [PORTS-1:0]   cfg_port_en;
  logic               stat_grant_valid;
  logic [1:0]         stat_grant_port;
  logic [PORTS-1:0]   stat_frame_done;

  logic [7:0]       src_data [PORTS];
  logic [7:0]       src_tid  [PORTS];
  logic [PORTS-1:0] src_valid, src_last;

  assign s_tvalid = src_valid;
  assign s_tlast  = src_last;
  assign s_tuser  = 4'b1000;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      s_tdata[p*8 +: 8] = src_data[p];
      s_tid[p*8 +: 8]   = src_tid[p];
    end
  end

  // PORTS=3 instance, completion path only
  logic [CW-1:0] s3_cpl_tdata, m3_cpl_tdata;
  logic [9:0]    s3_cpl_tid;
  logic          s3_cpl_tvalid, s3_cpl_tready;
  logic [23:0]   m3_cpl_tid;
  logic [2:0]    m3_cpl_tvalid, m3_cpl_tready;
  logic [2:0]    m3_s_tready, m3_frame_done;
  logic [7:0]    m3_tdata;
  logic          m3_tvalid, m3_tlast, m3_grant_valid;
  logic [0:0]    m3_tuser;
  logic [9:0]    m3_tid;
  logic [1:0]    m3_grant_port;

  taxi_eth_mac_tx_arb #(.PORTS(4)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tid(s_tid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tid(m_tid),
    .s_cpl_tdata(s_cpl_tdata), .s_cpl_tid(s_cpl_tid), .s_cpl_tvalid(s_cpl_tvalid),
    .s_cpl_tready(s_cpl_tready),
    .m_cpl_tdata(m_cpl_tdata), .m_cpl_tid(m_cpl_tid), .m_cpl_tvalid(m_cpl_tvalid),
    .m_cpl_tready(m_cpl_tready),
    .cfg_port_en(cfg_port_en), .stat_grant_valid(stat_grant_valid),
    .stat_grant_port(stat_grant_port), .stat_frame_done(stat_frame_done)
  );

  taxi_eth_mac_tx_arb #(.PORTS(3)) dut3 (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_tdata(24'h0), .s_tvalid(3'b0), .s_tready(m3_s_tready), .s_tlast(3'b0),
    .s_tuser(3'b0), .s_tid(24'h0),
    .m_tdata(m3_tdata), .m_tvalid(m3_tvalid), .m_tready(1'b1), .m_tlast(m3_tlast),
    .m_tuser(m3_tuser), .m_tid(m3_tid),
    .s_cpl_tdata(s3_cpl_tdata), .s_cpl_tid(s3_cpl_tid), .s_cpl_tvalid(s3_cpl_tvalid),
    .s_cpl_tready(s3_cpl_tready),
    .m_cpl_tdata(m3_cpl_tdata), .m_cpl_tid(m3_cpl_tid), .m_cpl_tvalid(m3_cpl_tvalid),
    .m_cpl_tready(m3_cpl_tready),
    .cfg_port_en(3'b111), .stat_grant_valid(m3_grant_valid),
    .stat_grant_port(m3_grant_port), .stat_frame_done(m3_frame_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int    exp_grant [$];
  beat_t exp_beat  [PORTS][$];
  done_t exp_done  [$];
  cpl_t  exp_cpl   [$];

  logic ready_toggle  = 1'b0;
  logic gap_check     = 1'b0;
  int   prev_last_cyc = -1;
  logic in_frame      = 1'b0;
  int   cur_port      = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge tx_clk) cyc <= cyc + 1;

  // m_tready: constant 1, or toggling every cycle
  always @(posedge tx_clk) begin
    #1;
    m_tready = ready_toggle ? ~m_tready : 1'b1;
  end

  // Monitor: TX beats, frame-done pulses and completions against the scoreboard queues
  always @(negedge tx_clk) begin
    if (tx_rst) begin
      in_frame = 1'b0;
    end else begin
      if (!stat_grant_valid)
        check("idle_outputs", 128'({m_tvalid, s_tready}), 128'(0));
      if (m_tvalid && m_tready) begin
        if (!in_frame) begin
          if (exp_grant.size() == 0) begin
            check("grant_unexpected", 128'(m_tid[9:8]), 128'hFF);
            cur_port = int'(m_tid[9:8]);
          end else begin
            cur_port = exp_grant.pop_front();
            check("grant_port", 128'(m_tid[9:8]), 128'(cur_port));
          end
          if (gap_check && prev_last_cyc >= 0)
            check("frame_gap", 128'(cyc - prev_last_cyc), 128'(2));
          in_frame = 1'b1;
        end
        if (exp_beat[cur_port].size() == 0) begin
          check("beat_unexpected", 128'(m_tdata), 128'h1FF);
        end else begin
          beat_t b;
          b = exp_beat[cur_port].pop_front();
          check("beat", 128'({m_tdata, m_tlast, m_tuser, m_tid}),
                128'({b.data, b.last, b.user, b.tid}));
        end
        if (m_tlast) begin
          in_frame      = 1'b0;
          prev_last_cyc = cyc;
          exp_done.push_back('{port: cur_port, cyc: cyc + 1});
        end
      end
      if (stat_frame_done != '0) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 128'(stat_frame_done), 128'(0));
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("frame_done", 128'({stat_frame_done, 32'(cyc)}),
                128'({4'(1 << d.port), 32'(d.cyc)}));
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        if (m_cpl_tvalid[p] && m_cpl_tready[p]) begin
          if (exp_cpl.size() == 0) begin
            check("cpl_unexpected", 128'(p), 128'hFF);
          end else begin
            cpl_t c;
            c = exp_cpl.pop_front();
            check("cpl_port", 128'(p), 128'(c.port));
            check("cpl_tag", 128'(m_cpl_tid[p*8 +: 8]), 128'(c.tag));
            check("cpl_data", 128'(m_cpl_tdata), 128'(c.data));
          end
        end
      end
    end
  end

  task automatic wait_ready(input int p);
    int n;
    n = 0;
    @(negedge tx_clk);
    while (!s_tready[p]) begin
      n++;
      if (n > 2000) begin
        check("tx_ready_timeout", 128'(0), 128'(1));
        break;
      end
      @(negedge tx_clk);
    end
    @(posedge tx_clk);
    #1;
  endtask

  task automatic push_frame(input int p, input logic [7:0] tid, input int len, input logic [7:0] base);
    exp_grant.push_back(p);
    for (int b = 0; b < len; b++)
      exp_beat[p].push_back('{data: base + 8'(b), last: (b == len - 1), user: (p == 3),
                              tid: {2'(p), tid}});
  endtask

  task automatic send_frame(input int p, input logic [7:0] tid, input int len, input logic [7:0] base);
    src_valid[p] = 1'b1;
    src_tid[p]   = tid;
    for (int b = 0; b < len; b++) begin
      src_data[p] = base + 8'(b);
      src_last[p] = (b == len - 1);
      wait_ready(p);
    end
    src_valid[p] = 1'b0;
    src_last[p]  = 1'b0;
  endtask

  task automatic wait_cpl_ready();
    int n;
    n = 0;
    @(negedge tx_clk);
    while (!s_cpl_tready) begin
      n++;
      if (n > 100) begin
        check("cpl_ready_timeout", 128'(0), 128'(1));
        break;
      end
      @(negedge tx_clk);
    end
    @(posedge tx_clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge tx_clk);
    #1 tx_rst = 1'b1;
    repeat (2) @(posedge tx_clk);
    #1 tx_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    src_valid     = '0;
    src_last      = '0;
    for (int p = 0; p < PORTS; p++) begin
      src_data[p] = '0;
      src_tid[p]  = '0;
    end
    cfg_port_en   = 4'hF;
    s_cpl_tdata   = '0;
    s_cpl_tid     = '0;
    s_cpl_tvalid  = 1'b0;
    m_cpl_tready  = 4'hF;
    s3_cpl_tdata  = '0;
    s3_cpl_tid    = '0;
    s3_cpl_tvalid = 1'b0;
    m3_cpl_tready = 3'b111;

    // Reset state
    repeat (3) @(negedge tx_clk);
    check("rst_grant_valid", 128'(stat_grant_valid), 128'(0));
    check("rst_grant_port", 128'(stat_grant_port), 128'(0));
    check("rst_tx_handshake", 128'({m_tvalid, s_tready, stat_frame_done}), 128'(0));
    @(posedge tx_clk);
    #1 tx_rst = 1'b0;

    // Port 1 cut by reset at beat 3 of 10
    exp_grant.push_back(1);
    for (int b = 0; b < 3; b++)
      exp_beat[1].push_back('{data: 8'h10 + 8'(b), last: 1'b0, user: 1'b0, tid: 10'h1A1});
    src_valid[1] = 1'b1;
    src_tid[1]   = 8'hA1;
    for (int b = 0; b < 3; b++) begin
      src_data[1] = 8'h10 + 8'(b);
      src_last[1] = 1'b0;
      wait_ready(1);
    end
    check("pre_rst_grant_port", 128'(stat_grant_port), 128'(1));
    tx_rst       = 1'b1;
    src_valid[1] = 1'b0;
    @(negedge tx_clk);
    check("midrst_grant_valid", 128'(stat_grant_valid), 128'(0));
    check("midrst_grant_port", 128'(stat_grant_port), 128'(0));
    check("midrst_outputs", 128'({m_tvalid, s_tready, stat_frame_done}), 128'(0));
    @(posedge tx_clk);
    #1 tx_rst = 1'b0;
    push_frame(0, 8'h11, 2, 8'h20);
    push_frame(1, 8'hA2, 3, 8'h30);
    fork
      send_frame(0, 8'h11, 2, 8'h20);
      send_frame(1, 8'hA2, 3, 8'h30);
    join
    repeat (3) @(negedge tx_clk);

    // Ports 0 and 2 alternate with one idle cycle between frames
    pulse_reset();
    prev_last_cyc = -1;
    gap_check     = 1'b1;
    push_frame(0, 8'h01, 3, 8'h40);
    push_frame(2, 8'h02, 3, 8'h50);
    push_frame(0, 8'h03, 3, 8'h60);
    push_frame(2, 8'h04, 3, 8'h70);
    fork
      begin
        send_frame(0, 8'h01, 3, 8'h40);
        send_frame(0, 8'h03, 3, 8'h60);
      end
      begin
        send_frame(2, 8'h02, 3, 8'h50);
        send_frame(2, 8'h04, 3, 8'h70);
      end
    join
    repeat (3) @(negedge tx_clk);
    gap_check = 1'b0;
    check("alt_last_port", 128'(stat_grant_port), 128'(2));

    // Port 3, 64 beats with m_tready toggling
    push_frame(3, 8'h5A, 64, 8'h80);
    ready_toggle = 1'b1;
    send_frame(3, 8'h5A, 64, 8'h80);
    ready_toggle = 1'b0;
    repeat (3) @(negedge tx_clk);

    // Port 1 masked; port 0 disabled mid-frame finishes and hands over to 2
    cfg_port_en  = 4'b1101;
    src_valid[1] = 1'b1;
    src_tid[1]   = 8'hEE;
    src_data[1]  = 8'hEE;
    src_last[1]  = 1'b1;
    push_frame(0, 8'h21, 4, 8'hC0);
    push_frame(2, 8'h22, 2, 8'hD0);
    push_frame(3, 8'h23, 2, 8'hE0);
    fork
      send_frame(0, 8'h21, 4, 8'hC0);
      send_frame(2, 8'h22, 2, 8'hD0);
      send_frame(3, 8'h23, 2, 8'hE0);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge tx_clk);
          if (m_tvalid && m_tready && m_tid[9:8] == 2'd0 && m_tdata == 8'hC1) break;
        end
        @(posedge tx_clk);
        #1 cfg_port_en[0] = 1'b0;
      end
    join
    repeat (6) @(negedge tx_clk);
    check("masked_grant_valid", 128'(stat_grant_valid), 128'(0));
    check("masked_grant_port", 128'(stat_grant_port), 128'(3));
    check("masked_ready1", 128'(s_tready[1]), 128'(0));
    src_valid[1] = 1'b0;
    src_last[1]  = 1'b0;
    cfg_port_en  = 4'hF;

    // Completion to port 2 stalled 5 cycles, then one to port 0
    @(posedge tx_clk);
    #1;
    m_cpl_tready = 4'b1011;
    s_cpl_tid    = 10'h201;
    s_cpl_tdata  = 96'hA5A5_0000_1111_2222_3333_4444;
    s_cpl_tvalid = 1'b1;
    exp_cpl.push_back('{port: 2, tag: 8'h01, data: 96'hA5A5_0000_1111_2222_3333_4444});
    repeat (5) begin
      @(negedge tx_clk);
      check("cpl_stall_ready", 128'(s_cpl_tready), 128'(0));
      check("cpl_stall_valid", 128'(m_cpl_tvalid), 128'(4'b0100));
    end
    @(posedge tx_clk);
    #1 m_cpl_tready = 4'hF;
    wait_cpl_ready();
    s_cpl_tid    = 10'h0FF;
    s_cpl_tdata  = 96'h0F0F_F0F0_1234_5678_9ABC_DEF0;
    exp_cpl.push_back('{port: 0, tag: 8'hFF, data: 96'h0F0F_F0F0_1234_5678_9ABC_DEF0});
    wait_cpl_ready();
    s_cpl_tvalid = 1'b0;

    // PORTS=3: prefix 3 is drained, prefix 2 is routed
    s3_cpl_tid    = 10'h312;
    s3_cpl_tvalid = 1'b1;
    m3_cpl_tready = 3'b000;
    @(negedge tx_clk);
    check("p3_drop_ready", 128'(s3_cpl_tready), 128'(1));
    check("p3_drop_valid", 128'(m3_cpl_tvalid), 128'(0));
    @(posedge tx_clk);
    #1;
    s3_cpl_tid    = 10'h233;
    m3_cpl_tready = 3'b011;
    @(negedge tx_clk);
    check("p3_route_valid", 128'(m3_cpl_tvalid), 128'(3'b100));
    check("p3_route_tag", 128'(m3_cpl_tid[23:16]), 128'(8'h33));
    check("p3_route_stall", 128'(s3_cpl_tready), 128'(0));
    @(posedge tx_clk);
    #1 m3_cpl_tready = 3'b100;
    @(negedge tx_clk);
    check("p3_route_ready", 128'(s3_cpl_tready), 128'(1));
    @(posedge tx_clk);
    #1 s3_cpl_tvalid = 1'b0;

    // Everything expected was seen
    repeat (3) @(negedge tx_clk);
    check("left_grants", 128'(exp_grant.size()), 128'(0));
    check("left_done", 128'(exp_done.size()), 128'(0));
    check("left_cpl", 128'(exp_cpl.size()), 128'(0));
    for (int p = 0; p < PORTS; p++)
      check("left_beats", 128'(exp_beat[p].size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/taxi_eth_mac_tx_arb.md
Name: taxi_eth_mac_tx_arb

Overview:
Frame-granular round-robin arbiter that shares one MAC transmit stream (8-bit, tx_clk domain) between PORTS transmit queues. It sits between the per-queue TX FIFOs and the MAC TX input, and prefixes the winning port index onto tid. It also demultiplexes the MAC TX completion stream back to the originating queue using that tid prefix. No data buffering: once a port holds the grant, data passes through combinationally.

Parameters:
PORTS, 4, number of requesting queues (2..16)
DATA_W, 8, tdata width (MAC GMII path)
USER_W, 1, tuser width (bit 0 = bad-frame marker, passed through)
S_ID_W, 8, per-port tag width
CPL_W, 96, completion tdata width (PTP timestamp field)
CL_PORTS, max($clog2(PORTS),1), derived; not overridable
M_ID_W, CL_PORTS+S_ID_W, derived output tid width

Ports:
tx_clk  in  1  transmit clock
tx_rst  in  1  async active-high reset
s_tdata  in  PORTS*DATA_W  per-port data, port i at slice i
s_tvalid  in  PORTS  per-port valid
s_tready  out  PORTS  per-port ready
s_tlast  in  PORTS  per-port end of frame
s_tuser  in  PORTS*USER_W  per-port user
s_tid  in  PORTS*S_ID_W  per-port tag
m_tdata  out  DATA_W  to MAC
m_tvalid  out  1
m_tready  in  1
m_tlast  out  1
m_tuser  out  USER_W
m_tid  out  M_ID_W  {port index, s_tid}
s_cpl_tdata  in  CPL_W  completion from MAC
s_cpl_tid  in  M_ID_W
s_cpl_tvalid  in  1
s_cpl_tready  out  1
m_cpl_tdata  out  CPL_W  shared to all ports
m_cpl_tid  out  PORTS*S_ID_W  per-port tag (low S_ID_W bits of s_cpl_tid)
m_cpl_tvalid  out  PORTS
m_cpl_tready  in  PORTS
cfg_port_en  in  PORTS  per-port arbitration enable
stat_grant_valid  out  1  a frame is in progress
stat_grant_port  out  CL_PORTS  current/last granted port
stat_frame_done  out  PORTS  1-cycle pulse when port i's frame ends (tlast handshake)

Behaviour:
- Reset (tx_rst async, clock tx_clk): state IDLE, rr pointer 0, stat_grant_valid 0, stat_grant_port 0, stat_frame_done 0, all s_tready 0, m_tvalid 0. Upstream FIFOs share tx_rst; a frame cut by reset is not resumed.
- States: IDLE, XFER.
- IDLE: req = s_tvalid & cfg_port_en. If req != 0, select the first set bit searching upward from rr pointer with wrap. Register grant, go to XFER next cycle. All s_tready = 0 and m_tvalid = 0 in IDLE. Arbitration costs exactly 1 idle cycle per frame.
- XFER, combinational pass-through of granted port g:
  - m_tvalid = s_tvalid[g]; s_tready[g] = m_tready; other s_tready = 0.
  - m_tdata/tlast/tuser from slice g; m_tid = {g, s_tid[g]}.
- On m_tvalid & m_tready & m_tlast in XFER:
  - stat_frame_done[g] pulses next cycle.
  - rr pointer = (g+1) mod PORTS, with wrap at PORTS-1 to 0 for non-power-of-2 PORTS.
  - Go to IDLE.
- cfg_port_en deassert mid-frame: the frame completes; the port is masked only at the next arbitration.
- s_tvalid[g] low mid-frame: hold the grant and output m_tvalid 0 (MAC flags underflow; the arbiter never aborts).
- Single requester: back-to-back frames separated by 1 cycle.
- Full throughput within a frame: 1 beat/cycle when m_tready = 1.
- Completion demux, combinational, no state:
  - p = s_cpl_tid[M_ID_W-1:S_ID_W].
  - m_cpl_tvalid[p] = s_cpl_tvalid; s_cpl_tready = m_cpl_tready[p].
  - If p >= PORTS: s_cpl_tready = 1, completion discarded, no m_cpl_tvalid.
  - Completions are independent of the TX grant and may arrive during any state.
- stat_grant_valid = (state == XFER); stat_grant_port holds its last value in IDLE.

Decomposition:
- Shared package taxi_eth_mac_tx_arb_pkg:
  - state enum {IDLE, XFER}
  - function rr_select(req, ptr, PORTS) returning {found, index}
- One natural sub-module, taxi_eth_mac_tx_cpl_demux, for the completion routing (stateless, reusable by other MAC wrappers).
- Arbiter FSM and pass-through mux stay in the top module.

Test Plan:
- Reset mid-frame (port 1 beat 3 of 10) -> all outputs match reset values; next arbitration starts at port 0; port 1 re-requests with a new frame and wins normally.
- Ports 0,2 continuously requesting 3-beat frames, PORTS=4 -> grant sequence 0,2,0,2; m_tid[9:8] matches; stat_frame_done pulses alternate; 1 idle cycle between frames.
- Port 3 only, tid 0x5A, 64-beat frame with m_tready toggling 50% -> 64 beats in order, m_tid=0x35A throughout, no drop/duplicate, tlast on beat 64 only.
- cfg_port_en=4'b1101 with all 4 requesting -> port 1 never granted; clear bit 0 mid-frame of port 0 -> frame finishes, next grant is 2.
- Completion tids 0x201, 0x0FF with m_cpl_tready[2]=0 for 5 cycles -> port 2 receives tag 0x01 after stall; port 0 receives 0xFF; s_cpl_tready low during the stall.
- PORTS=3, completion tid prefix 3 -> accepted and dropped; no m_cpl_tvalid asserted.
